// File: rtl/cgra_io_driver_if.sv
// Host, run-control and PE-array lanes of the CGRA I/O driver.
// Signal names are as seen from the driver (slave) side.
interface cgra_io_driver_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 6
);
  logic              i_start;
  logic [AWIDTH:0]   i_length;
  logic              i_host_wr_en;
  logic              i_host_wr_lane;
  logic [AWIDTH-1:0] i_host_wr_addr;
  logic [DWIDTH-1:0] i_host_wr_data;
  logic              i_host_rd_lane;
  logic [AWIDTH-1:0] i_host_rd_addr;
  logic [DWIDTH-1:0] o_host_rd_data;
  logic [DWIDTH-1:0] o_data0_load;
  logic [DWIDTH-1:0] o_data1_load;
  logic [DWIDTH-1:0] i_data0_store;
  logic [DWIDTH-1:0] i_data1_store;
  logic              o_pe_array_busy;
  logic              o_busy;
  logic              o_done;

  modport slave (
    input  i_start, i_length,
    input  i_host_wr_en, i_host_wr_lane,
    input  i_host_wr_addr, i_host_wr_data,
    input  i_host_rd_lane, i_host_rd_addr,
    input  i_data0_store, i_data1_store,
    output o_host_rd_data,
    output o_data0_load, o_data1_load,
    output o_pe_array_busy, o_busy, o_done
  );

  modport master (
    output i_start, i_length,
    output i_host_wr_en, i_host_wr_lane,
    output i_host_wr_addr, i_host_wr_data,
    output i_host_rd_lane, i_host_rd_addr,
    output i_data0_store, i_data1_store,
    input  o_host_rd_data,
    input  o_data0_load, o_data1_load,
    input  o_pe_array_busy, o_busy, o_done
  );
endinterface

// File: rtl/cgra_io_driver.sv
// Two-lane load/store buffer driver feeding a CGRA PE array.
// Loads stream buf[k] out while stores capture the array result at k.
module cgra_io_driver #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 6
) (
  input logic             i_clk,
  input logic             i_rst,
  cgra_io_driver_if.slave io
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [AWIDTH-1:0] r_k;
  logic [AWIDTH-1:0] r_last;
  logic [DWIDTH-1:0] r_load0;
  logic [DWIDTH-1:0] r_load1;
  logic [DWIDTH-1:0] r_rd_data;
  logic              r_pe_busy;
  logic              r_busy;
  logic              r_done;

  logic [DWIDTH-1:0] r_ld0 [DEPTH];
  logic [DWIDTH-1:0] r_ld1 [DEPTH];
  logic [DWIDTH-1:0] r_st0 [DEPTH];
  logic [DWIDTH-1:0] r_st1 [DEPTH];

  logic [AWIDTH:0]   w_len;
  logic [AWIDTH:0]   w_last_full;
  logic [AWIDTH-1:0] w_k_nxt;

  assign w_len = (io.i_length > DEPTH_W) ? DEPTH_W : io.i_length;
  assign w_last_full = w_len - (AWIDTH+1)'(1);
  assign w_k_nxt = r_k + AWIDTH'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_last    <= '0;
      r_load0   <= '0;
      r_load1   <= '0;
      r_pe_busy <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (io.i_start) begin
            r_busy <= 1'b1;
            r_k    <= '0;
            r_last <= w_last_full[AWIDTH-1:0];
            if (w_len != '0) begin
              r_state   <= S_RUN;
              r_pe_busy <= 1'b1;
              r_load0   <= r_ld0[0];
              r_load1   <= r_ld1[0];
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (r_k == r_last) begin
            r_state   <= S_DONE;
            r_pe_busy <= 1'b0;
            r_done    <= 1'b1;
            r_load0   <= '0;
            r_load1   <= '0;
          end else begin
            r_k     <= w_k_nxt;
            r_load0 <= r_ld0[w_k_nxt];
            r_load1 <= r_ld1[w_k_nxt];
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Buffers survive reset; a reset edge mid-run captures nothing.
  always_ff @(posedge i_clk) begin
    if (io.i_host_wr_en && r_state != S_RUN) begin
      if (io.i_host_wr_lane)
        r_ld1[io.i_host_wr_addr] <= io.i_host_wr_data;
      else
        r_ld0[io.i_host_wr_addr] <= io.i_host_wr_data;
    end
    if (r_state == S_RUN && !i_rst) begin
      r_st0[r_k] <= io.i_data0_store;
      r_st1[r_k] <= io.i_data1_store;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rd_data <= '0;
    else if (io.i_host_rd_lane)
      r_rd_data <= r_st1[io.i_host_rd_addr];
    else
      r_rd_data <= r_st0[io.i_host_rd_addr];
  end

  assign io.o_host_rd_data  = r_rd_data;
  assign io.o_data0_load    = r_load0;
  assign io.o_data1_load    = r_load1;
  assign io.o_pe_array_busy = r_pe_busy;
  assign io.o_busy          = r_busy;
  assign io.o_done          = r_done;

endmodule

// File: tb/tb_cgra_io_driver.sv
// Directed bench for cgra_io_driver with a multiply-by-N array model.
// Inputs change and outputs are sampled on the falling edge.
module tb_cgra_io_driver;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  logic [DW-1:0] mult = 32'd2;
  logic [DW-1:0] rdv;

  always #5 clk = ~clk;

  cgra_io_driver_if #(.DWIDTH(DW), .AWIDTH(AW)) io ();

  cgra_io_driver #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io    (io.slave)
  );

  assign io.i_data0_store = io.o_data0_load * mult;
  assign io.i_data1_store = io.o_data1_load * mult;

  task automatic chk(input string tag, input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic host_wr(input logic lane, input int addr,
                         input logic [DW-1:0] data);
    io.i_host_wr_en   = 1'b1;
    io.i_host_wr_lane = lane;
    io.i_host_wr_addr = AW'(addr);
    io.i_host_wr_data = data;
    @(negedge clk);
    io.i_host_wr_en = 1'b0;
  endtask

  task automatic host_rd(input logic lane, input int addr,
                         output logic [DW-1:0] data);
    io.i_host_rd_lane = lane;
    io.i_host_rd_addr = AW'(addr);
    @(negedge clk);
    data = io.o_host_rd_data;
  endtask

  task automatic go(input int len);
    io.i_start  = 1'b1;
    io.i_length = (AW+1)'(len);
    @(negedge clk);
    io.i_start = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_busy"}, DW'(io.o_busy), 0);
    chk({tag, "_pebusy"}, DW'(io.o_pe_array_busy), 0);
    chk({tag, "_done"}, DW'(io.o_done), 0);
    chk({tag, "_ld0"}, io.o_data0_load, 0);
    chk({tag, "_ld1"}, io.o_data1_load, 0);
    chk({tag, "_rd"}, io.o_host_rd_data, 0);
  endtask

  initial begin
    int nb;
    int nd;
    io.i_start = 1'b0;
    io.i_length = '0;
    io.i_host_wr_en = 1'b0;
    io.i_host_wr_lane = 1'b0;
    io.i_host_wr_addr = '0;
    io.i_host_wr_data = '0;
    io.i_host_rd_lane = 1'b0;
    io.i_host_rd_addr = '0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      host_wr(1'b0, i, DW'(i + 1));
      host_wr(1'b1, i, DW'(32'h100 + i));
    end

    // Length 4 basic run
    go(4);
    for (int c = 0; c < 4; c++) begin
      chk("r4_pebusy", DW'(io.o_pe_array_busy), 1);
      chk("r4_ld0", io.o_data0_load, DW'(c + 1));
      chk("r4_ld1", io.o_data1_load, DW'(32'h100 + c));
      @(negedge clk);
    end
    chk("r4_done", DW'(io.o_done), 1);
    chk("r4_done_pebusy", DW'(io.o_pe_array_busy), 0);
    chk("r4_done_ld0", io.o_data0_load, 0);
    chk("r4_done_busy", DW'(io.o_busy), 1);
    @(negedge clk);
    chk("r4_idle_done", DW'(io.o_done), 0);
    chk("r4_idle_busy", DW'(io.o_busy), 0);
    for (int i = 0; i < 4; i++) begin
      host_rd(1'b0, i, rdv);
      chk("r4_st0", rdv, DW'(2 * (i + 1)));
    end
    host_rd(1'b1, 0, rdv);
    chk("r4_st1_0", rdv, 32'h200);

    // Zero length
    go(0);
    chk("z_done", DW'(io.o_done), 1);
    chk("z_pebusy", DW'(io.o_pe_array_busy), 0);
    chk("z_ld0", io.o_data0_load, 0);
    @(negedge clk);
    chk("z_idle", DW'(io.o_busy), 0);
    host_rd(1'b0, 0, rdv);
    chk("z_st0", rdv, 32'd2);

    // Start and host write during RUN are ignored
    go(4);
    chk("ign_k0", io.o_data0_load, 1);
    @(negedge clk);
    chk("ign_k1", io.o_data0_load, 2);
    io.i_start = 1'b1;
    io.i_length = 7'd2;
    host_wr(1'b0, 2, 32'hDEAD);
    io.i_start = 1'b0;
    chk("ign_k2", io.o_data0_load, 3);
    @(negedge clk);
    chk("ign_k3", io.o_data0_load, 4);
    @(negedge clk);
    chk("ign_done", DW'(io.o_done), 1);
    @(negedge clk);
    chk("ign_idle", DW'(io.o_busy), 0);
    @(negedge clk);
    chk("ign_norestart", DW'(io.o_busy), 0);

    // Over-length run clamps to DEPTH
    go(DEPTH + 5);
    nb = 0;
    nd = 0;
    for (int c = 0; c < DEPTH + 20; c++) begin
      if (io.o_pe_array_busy) begin
        if (io.o_data0_load !== DW'(nb + 1))
          chk("ovl_ld0", io.o_data0_load, DW'(nb + 1));
        nb++;
      end
      if (io.o_done) nd++;
      @(negedge clk);
    end
    chk("ovl_cycles", DW'(nb), DW'(DEPTH));
    chk("ovl_donecnt", DW'(nd), 1);
    chk("ovl_idle", DW'(io.o_busy), 0);
    for (int i = 0; i < DEPTH; i++) begin
      host_rd(1'b0, i, rdv);
      chk("ovl_st0", rdv, DW'(2 * (i + 1)));
    end

    // Host write with Start: prefetch sees old lane1[0]
    io.i_host_wr_en = 1'b1;
    io.i_host_wr_lane = 1'b1;
    io.i_host_wr_addr = '0;
    io.i_host_wr_data = 32'h555;
    go(1);
    io.i_host_wr_en = 1'b0;
    chk("wrs_old", io.o_data1_load, 32'h100);
    repeat (2) @(negedge clk);
    go(1);
    chk("wrs_new", io.o_data1_load, 32'h555);
    repeat (2) @(negedge clk);

    // Reset in RUN cycle k=2
    mult = 32'd3;
    go(8);
    @(negedge clk);
    @(negedge clk);
    chk("rr_k2", io.o_data0_load, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_rst("rr");
    @(negedge clk);
    chk("rr_nodone", DW'(io.o_done), 0);
    host_rd(1'b0, 0, rdv);
    chk("rr_st0_0", rdv, 32'd3);
    host_rd(1'b0, 1, rdv);
    chk("rr_st0_1", rdv, 32'd6);
    host_rd(1'b0, 3, rdv);
    chk("rr_st0_3", rdv, 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cgra_io_driver.md
CGRA_IO_DRIVER -- requirements
Module: cgra_io_driver

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, giving the data word width of every load/store lane.
REQ-002 SHALL have parameter AWIDTH, default 6, giving the buffer address width; DEPTH = 2^AWIDTH words per lane.
REQ-003 Clk  input  1  single clock; all logic rising-edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-006 Length  input  AWIDTH+1  number of array compute cycles; sampled on an accepted Start.
REQ-007 Host_Wr_En  input  1  host write strobe into load buffers.
REQ-008 Host_Wr_Lane  input  1  0 selects lane 0 buffer, 1 selects lane 1 buffer.
REQ-009 Host_Wr_Addr  input  AWIDTH  load buffer write address.
REQ-010 Host_Wr_Data  input  DWIDTH  load buffer write data.
REQ-011 Host_Rd_Lane  input  1  store buffer lane select.
REQ-012 Host_Rd_Addr  input  AWIDTH  store buffer read address.
REQ-013 Host_Rd_Data  output  DWIDTH  store buffer read data, 1-cycle latency.
REQ-014 Data0_Load  output  DWIDTH  lane 0 word driven into the PE array.
REQ-015 Data1_Load  output  DWIDTH  lane 1 word driven into the PE array.
REQ-016 Data0_Store  input  DWIDTH  lane 0 word returned by the PE array.
REQ-017 Data1_Store  input  DWIDTH  lane 1 word returned by the PE array.
REQ-018 PE_Array_Busy  output  1  high exactly during RUN cycles.
REQ-019 Busy  output  1  high in every state except IDLE.
REQ-020 Done  output  1  one-cycle pulse at end of run.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-022 IDLE + Start + Length!=0 -> RUN next cycle; run counter k cleared to 0; effective length L = min(Length, DEPTH).
REQ-023 IDLE + Start + Length==0 -> DONE next cycle; PE_Array_Busy never asserts; store buffers unchanged.
REQ-024 Start outside IDLE SHALL be ignored with no side effect.
REQ-025 On accepted Start, Data0_Load/Data1_Load SHALL be registered with load_buf0[0]/load_buf1[0], valid in RUN cycle k=0.
REQ-026 In RUN cycle k (0..L-1): Data0_Load = load_buf0[k], Data1_Load = load_buf1[k], PE_Array_Busy = 1.
REQ-027 In RUN cycle k, Data0_Store/Data1_Store SHALL be written into store_buf0[k]/store_buf1[k] at that cycle's rising edge.
REQ-028 After RUN cycle k = L-1 -> DONE; Done = 1, PE_Array_Busy = 0, Data0_Load/Data1_Load = 0.
REQ-029 In IDLE and DONE, Data0_Load/Data1_Load SHALL be 0.
REQ-030 k SHALL count to at most DEPTH-1 with no wrap; L = DEPTH writes every store address exactly once.
REQ-031 Host writes SHALL take effect in IDLE and DONE only; writes while Busy=1 in RUN SHALL be dropped.
REQ-032 Host reads SHALL be allowed in any state; a read of a store address written in the same cycle returns the old value.
REQ-033 Host write and accepted Start in the same cycle: the write SHALL complete and the prefetch of address 0 SHALL see the pre-write value.

Reset
REQ-034 Reset SHALL force IDLE, k=0, PE_Array_Busy=0, Busy=0, Done=0, Data0_Load=Data1_Load=0, Host_Rd_Data=0.
REQ-035 Reset SHALL NOT clear buffer contents; Reset mid-RUN aborts the run with no Done and with store words already captured retained.

Verification
REQ-036 Load lane0[i]=i+1, lane1[i]=0x100+i, Start with Length=4 -> PE_Array_Busy high 4 cycles, Data0_Load 1,2,3,4, Data1_Load 0x100..0x103, Done pulse on 5th cycle after Start.
REQ-037 Array model returns Store = Load*2 -> store_buf0[0..3] reads 2,4,6,8 via Host_Rd_Data one cycle after each address.
REQ-038 Start with Length=0 -> Done one cycle later, PE_Array_Busy stays 0, store buffers unchanged.
REQ-039 Start with Length=DEPTH+5 -> exactly DEPTH busy cycles, no address wrap, all DEPTH store entries written.
REQ-040 Start pulsed again in RUN plus host write to lane0[2] in RUN -> run unaffected, lane0[2] retains old value.
REQ-041 Reset asserted in RUN cycle k=2 of Length=8 -> next cycle all outputs at reset values, no Done, store_buf0[0..1] retain captured values.
